// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decode-side inputs, EX-side registered outputs, stall/flush and hazard handshake.
interface id_ex_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
);
  logic              stall_i;
  logic              flush_i;
  logic              RegDst_i, ALUSrc_i, MemRead_i, MemWrite_i, MemtoReg_i, RegWrite_i;
  logic [1:0]        ALUOp_i;
  logic [DATA_W-1:0] rs_data_i, rt_data_i, imm_i;
  logic [4:0]        rs_addr_i, rt_addr_i, rd_addr_i;

  logic              RegDst_o, ALUSrc_o, MemRead_o, MemWrite_o, MemtoReg_o, RegWrite_o;
  logic [1:0]        ALUOp_o;
  logic [DATA_W-1:0] rs_data_o, rt_data_o, imm_o;
  logic [4:0]        rs_addr_o, rt_addr_o, rd_addr_o;
  logic              valid_o;
  logic              hazard_o;
  logic              pc_write_o;
  logic              ifid_write_o;
  logic [CNT_W-1:0]  bubble_cnt_o;

  modport slave (
    input  stall_i, flush_i,
    input  RegDst_i, ALUSrc_i, MemRead_i, MemWrite_i, MemtoReg_i, RegWrite_i, ALUOp_i,
    input  rs_data_i, rt_data_i, imm_i, rs_addr_i, rt_addr_i, rd_addr_i,
    output RegDst_o, ALUSrc_o, MemRead_o, MemWrite_o, MemtoReg_o, RegWrite_o, ALUOp_o,
    output rs_data_o, rt_data_o, imm_o, rs_addr_o, rt_addr_o, rd_addr_o,
    output valid_o, hazard_o, pc_write_o, ifid_write_o, bubble_cnt_o
  );

  modport master (
    output stall_i, flush_i,
    output RegDst_i, ALUSrc_i, MemRead_i, MemWrite_i, MemtoReg_i, RegWrite_i, ALUOp_i,
    output rs_data_i, rt_data_i, imm_i, rs_addr_i, rt_addr_i, rd_addr_i,
    input  RegDst_o, ALUSrc_o, MemRead_o, MemWrite_o, MemtoReg_o, RegWrite_o, ALUOp_o,
    input  rs_data_o, rt_data_o, imm_o, rs_addr_o, rt_addr_o, rd_addr_o,
    input  valid_o, hazard_o, pc_write_o, ifid_write_o, bubble_cnt_o
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// global stall/flush handling and a saturating bubble counter.
module id_ex_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  id_ex_stage_if.slave  bus
);

  localparam int unsigned AW = 5;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic [1:0] alu_op;
  } ctrl_t;

  ctrl_t             ctrl_q, ctrl_d, ctrl_in;
  logic [DATA_W-1:0] rs_data_q, rs_data_d, rt_data_q, rt_data_d, imm_q, imm_d;
  logic [AW-1:0]     rs_addr_q, rs_addr_d, rt_addr_q, rt_addr_d, rd_addr_q, rd_addr_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              hazard_c;
  logic              bubble_c;

  assign ctrl_in = '{reg_dst:    bus.RegDst_i,
                     alu_src:    bus.ALUSrc_i,
                     mem_read:   bus.MemRead_i,
                     mem_write:  bus.MemWrite_i,
                     mem_to_reg: bus.MemtoReg_i,
                     reg_write:  bus.RegWrite_i,
                     alu_op:     bus.ALUOp_i};

  // Load in EX whose destination rt is a source of the ID instruction; rt compared for every opcode.
  assign hazard_c = valid_q & ctrl_q.mem_read & (rt_addr_q != AW'(0)) &
                    ((rt_addr_q == bus.rs_addr_i) | (rt_addr_q == bus.rt_addr_i));
  assign bubble_c = bus.flush_i | hazard_c;

  // Stall holds everything; flush/hazard inserts one counted bubble; otherwise load.
  always_comb begin
    ctrl_d    = ctrl_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    rs_addr_d = rs_addr_q;
    rt_addr_d = rt_addr_q;
    rd_addr_d = rd_addr_q;
    valid_d   = valid_q;
    cnt_d     = cnt_q;
    if (!bus.stall_i) begin
      rs_data_d = bus.rs_data_i;
      rt_data_d = bus.rt_data_i;
      imm_d     = bus.imm_i;
      rs_addr_d = bus.rs_addr_i;
      rt_addr_d = bus.rt_addr_i;
      rd_addr_d = bus.rd_addr_i;
      if (bubble_c) begin
        ctrl_d  = '0;
        valid_d = 1'b0;
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
      end else begin
        ctrl_d  = ctrl_in;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ctrl_q    <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      rs_addr_q <= '0;
      rt_addr_q <= '0;
      rd_addr_q <= '0;
      valid_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      rs_addr_q <= rs_addr_d;
      rt_addr_q <= rt_addr_d;
      rd_addr_q <= rd_addr_d;
      valid_q   <= valid_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.RegDst_o     = ctrl_q.reg_dst;
  assign bus.ALUSrc_o     = ctrl_q.alu_src;
  assign bus.MemRead_o    = ctrl_q.mem_read;
  assign bus.MemWrite_o   = ctrl_q.mem_write;
  assign bus.MemtoReg_o   = ctrl_q.mem_to_reg;
  assign bus.RegWrite_o   = ctrl_q.reg_write;
  assign bus.ALUOp_o      = ctrl_q.alu_op;
  assign bus.rs_data_o    = rs_data_q;
  assign bus.rt_data_o    = rt_data_q;
  assign bus.imm_o        = imm_q;
  assign bus.rs_addr_o    = rs_addr_q;
  assign bus.rt_addr_o    = rt_addr_q;
  assign bus.rd_addr_o    = rd_addr_q;
  assign bus.valid_o      = valid_q;
  assign bus.bubble_cnt_o = cnt_q;
  assign bus.hazard_o     = hazard_c;
  assign bus.pc_write_o   = ~bus.stall_i & ~hazard_c;
  assign bus.ifid_write_o = ~bus.stall_i & ~hazard_c;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: reset, pass-through, load-use,
// flush+hazard, stall hold and counter saturation.
module tb_id_ex_stage;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   total = 0;
  int   bad   = 0;

  id_ex_stage_if #(.DATA_W(32), .CNT_W(16)) bus ();

  id_ex_stage #(.DATA_W(32), .CNT_W(16)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // ctrl packs {RegDst, ALUSrc, MemRead, MemWrite, MemtoReg, RegWrite, ALUOp[1:0]}
  task automatic drive(input logic [7:0] ctrl, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd,
                       input logic [31:0] imm);
    bus.RegDst_i   = ctrl[7];
    bus.ALUSrc_i   = ctrl[6];
    bus.MemRead_i  = ctrl[5];
    bus.MemWrite_i = ctrl[4];
    bus.MemtoReg_i = ctrl[3];
    bus.RegWrite_i = ctrl[2];
    bus.ALUOp_i    = ctrl[1:0];
    bus.rs_addr_i  = rs;
    bus.rt_addr_i  = rt;
    bus.rd_addr_i  = rd;
    bus.rs_data_i  = rsd;
    bus.rt_data_i  = rtd;
    bus.imm_i      = imm;
  endtask

  localparam logic [7:0] C_ADDI = 8'b0100_0100;
  localparam logic [7:0] C_RTYP = 8'b1000_0111;
  localparam logic [7:0] C_ADD  = 8'b1000_0110;
  localparam logic [7:0] C_LW   = 8'b0110_1100;

  initial begin
    bus.stall_i = 1'b0;
    bus.flush_i = 1'b0;
    drive(8'h00, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    #2;
    chk("rst_valid",  32'(bus.valid_o), 32'd0);
    chk("rst_cnt",    32'(bus.bubble_cnt_o), 32'd0);
    chk("rst_hazard", 32'(bus.hazard_o), 32'd0);
    chk("rst_pcw",    32'(bus.pc_write_o), 32'd1);

    #1 rst_i = 1'b1;
    drive(C_ADDI, 5'd0, 5'd8, 5'd0, 32'h0, 32'h0, 32'h5);
    step();
    chk("addi_regwrite", 32'(bus.RegWrite_o), 32'd1);

    // Asynchronous reset between edges
    #1 rst_i = 1'b0;
    #1;
    chk("arst_regwrite", 32'(bus.RegWrite_o), 32'd0);
    chk("arst_alusrc",   32'(bus.ALUSrc_o), 32'd0);
    chk("arst_valid",    32'(bus.valid_o), 32'd0);
    chk("arst_imm",      bus.imm_o, 32'd0);
    #1 rst_i = 1'b1;
    step();
    chk("post_rst_valid",    32'(bus.valid_o), 32'd1);
    chk("post_rst_alusrc",   32'(bus.ALUSrc_o), 32'd1);
    chk("post_rst_regwrite", 32'(bus.RegWrite_o), 32'd1);
    chk("post_rst_imm",      bus.imm_o, 32'h5);

    // R-type pass-through
    drive(C_RTYP, 5'd8, 5'd9, 5'd10, 32'h11, 32'h22, 32'h0);
    step();
    chk("rt_aluop",  32'(bus.ALUOp_o), 32'd3);
    chk("rt_regdst", 32'(bus.RegDst_o), 32'd1);
    chk("rt_rd",     32'(bus.rd_addr_o), 32'd10);
    chk("rt_rsd",    bus.rs_data_o, 32'h11);
    chk("rt_rtd",    bus.rt_data_o, 32'h22);
    chk("rt_hazard", 32'(bus.hazard_o), 32'd0);

    // Load-use: lw rt=9, then add rs=9
    drive(C_LW, 5'd8, 5'd9, 5'd0, 32'h100, 32'h0, 32'h4);
    step();
    drive(C_ADD, 5'd9, 5'd10, 5'd11, 32'h0, 32'h0, 32'h0);
    #1;
    chk("lu_hazard", 32'(bus.hazard_o), 32'd1);
    chk("lu_pcw",    32'(bus.pc_write_o), 32'd0);
    chk("lu_ifidw",  32'(bus.ifid_write_o), 32'd0);
    step();
    chk("lu_bub_valid",   32'(bus.valid_o), 32'd0);
    chk("lu_bub_memread", 32'(bus.MemRead_o), 32'd0);
    chk("lu_bub_regwr",   32'(bus.RegWrite_o), 32'd0);
    chk("lu_bub_cnt",     32'(bus.bubble_cnt_o), 32'd1);
    chk("lu_bub_hazard",  32'(bus.hazard_o), 32'd0);
    chk("lu_bub_pcw",     32'(bus.pc_write_o), 32'd1);
    step();
    chk("lu_add_valid", 32'(bus.valid_o), 32'd1);
    chk("lu_add_rd",    32'(bus.rd_addr_o), 32'd11);
    chk("lu_add_aluop", 32'(bus.ALUOp_o), 32'd2);
    chk("lu_add_cnt",   32'(bus.bubble_cnt_o), 32'd1);

    // rt match also triggers a hazard
    drive(C_LW, 5'd8, 5'd9, 5'd0, 32'h0, 32'h0, 32'h0);
    step();
    drive(C_ADD, 5'd3, 5'd9, 5'd4, 32'h0, 32'h0, 32'h0);
    #1;
    chk("rtm_hazard", 32'(bus.hazard_o), 32'd1);
    step();
    chk("rtm_cnt", 32'(bus.bubble_cnt_o), 32'd2);
    step();

    // lw to $0 never causes a hazard
    drive(C_LW, 5'd8, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    step();
    drive(C_ADD, 5'd0, 5'd0, 5'd5, 32'h0, 32'h0, 32'h0);
    #1;
    chk("zero_hazard", 32'(bus.hazard_o), 32'd0);
    chk("zero_pcw",    32'(bus.pc_write_o), 32'd1);
    step();
    chk("zero_valid", 32'(bus.valid_o), 32'd1);
    chk("zero_cnt",   32'(bus.bubble_cnt_o), 32'd2);

    // Flush and hazard together: one bubble, counted once
    drive(C_LW, 5'd8, 5'd9, 5'd0, 32'h0, 32'h0, 32'h0);
    step();
    drive(C_ADD, 5'd9, 5'd1, 5'd6, 32'h0, 32'h0, 32'h0);
    bus.flush_i = 1'b1;
    #1;
    chk("fh_hazard", 32'(bus.hazard_o), 32'd1);
    step();
    bus.flush_i = 1'b0;
    chk("fh_valid", 32'(bus.valid_o), 32'd0);
    chk("fh_cnt",   32'(bus.bubble_cnt_o), 32'd3);
    step();
    chk("fh_next_valid", 32'(bus.valid_o), 32'd1);
    chk("fh_next_rd",    32'(bus.rd_addr_o), 32'd6);

    // Stall with a pending hazard: hold for 5 cycles, then one bubble
    drive(C_LW, 5'd8, 5'd9, 5'd7, 32'h33, 32'h44, 32'h0);
    step();
    bus.stall_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(C_ADD, 5'd9, 5'(i), 5'(20 + i), 32'(i + 100), 32'(i), 32'(i));
      bus.flush_i = i[0];
      step();
      chk("stl_rsd",     bus.rs_data_o, 32'h33);
      chk("stl_rd",      32'(bus.rd_addr_o), 32'd7);
      chk("stl_memread", 32'(bus.MemRead_o), 32'd1);
      chk("stl_cnt",     32'(bus.bubble_cnt_o), 32'd3);
      chk("stl_hazard",  32'(bus.hazard_o), 32'd1);
      chk("stl_pcw",     32'(bus.pc_write_o), 32'd0);
    end
    bus.flush_i = 1'b0;
    drive(C_ADD, 5'd9, 5'd2, 5'd12, 32'h0, 32'h0, 32'h0);
    bus.stall_i = 1'b0;
    #1;
    chk("stl_rel_pcw", 32'(bus.pc_write_o), 32'd0);
    step();
    chk("stl_bub_valid", 32'(bus.valid_o), 32'd0);
    chk("stl_bub_cnt",   32'(bus.bubble_cnt_o), 32'd4);
    step();
    chk("stl_add_valid", 32'(bus.valid_o), 32'd1);
    chk("stl_add_rd",    32'(bus.rd_addr_o), 32'd12);

    // Saturation: run counter to 0xFFFE, then three more bubbles
    bus.flush_i = 1'b1;
    repeat (16'hFFFE - 4) @(posedge clk_i);
    #1;
    chk("sat_pre", 32'(bus.bubble_cnt_o), 32'hFFFE);
    repeat (3) step();
    chk("sat_cnt", 32'(bus.bubble_cnt_o), 32'hFFFF);
    bus.flush_i = 1'b0;
    step();
    chk("sat_hold",  32'(bus.bubble_cnt_o), 32'hFFFF);
    chk("sat_valid", 32'(bus.valid_o), 32'd1);

    #1 rst_i = 1'b0;
    #1;
    chk("final_rst_cnt", 32'(bus.bubble_cnt_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
